// File: rtl/gate_bist_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gate_bist_ctrl_if : BIST sequencer <-> gate unit / controller bundle |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface gate_bist_ctrl_if;
  logic       start;
  logic       A_drv;
  logic       B_drv;
  logic       AND_in;
  logic       OR_in;
  logic       NOT_A_in;
  logic       NAND_in;
  logic       NOR_in;
  logic       XOR_in;
  logic       XNOR_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] fail_vec;
  logic [2:0] fail_cnt;
  logic [1:0] first_fail_idx;

  modport master (
    input  start, AND_in, OR_in, NOT_A_in, NAND_in, NOR_in, XOR_in, XNOR_in,
    output A_drv, B_drv, busy, done, pass, fail_vec, fail_cnt, first_fail_idx
  );

  modport slave (
    output start, AND_in, OR_in, NOT_A_in, NAND_in, NOR_in, XOR_in, XNOR_in,
    input  A_drv, B_drv, busy, done, pass, fail_vec, fail_cnt, first_fail_idx
  );
endinterface
`default_nettype wire

// File: rtl/gate_bist_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gate_bist_ctrl : walks A/B through 00,01,10,11 and grades 7 gates    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gate_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_bist_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [6:0] fail_vec_q, fail_vec_d;
  logic [2:0] fail_cnt_q, fail_cnt_d;
  logic [1:0] ffi_q, ffi_d;

  logic       op_a;
  logic       op_b;
  logic [6:0] exp_bits;
  logic [6:0] obs_bits;
  logic [6:0] mismatch;

  assign op_a     = vec_q[1];
  assign op_b     = vec_q[0];
  assign exp_bits = {~(op_a ^ op_b), op_a ^ op_b, ~(op_a | op_b), ~(op_a & op_b),
                     ~op_a, op_a | op_b, op_a & op_b};
  assign obs_bits = {bus.XNOR_in, bus.XOR_in, bus.NOR_in, bus.NAND_in,
                     bus.NOT_A_in, bus.OR_in, bus.AND_in};

  // if/else rather than != so an unknown observed bit lands on the mismatch branch
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < 7; i++) begin
      if (obs_bits[i] == exp_bits[i]) mismatch[i] = 1'b0;
      else                            mismatch[i] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    fail_cnt_d = fail_cnt_q;
    ffi_d      = ffi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pass_d     = 1'b0;
          fail_vec_d = '0;
          fail_cnt_d = '0;
          ffi_d      = '0;
          vec_d      = 2'd0;
          cnt_d      = SETTLE_LOAD;
          busy_d     = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        fail_vec_d = fail_vec_q | mismatch;
        if (|mismatch) begin
          fail_cnt_d = fail_cnt_q + 3'd1;
          if (fail_cnt_q == 3'd0) ffi_d = vec_q;
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        // fail_cnt_q already holds the last CHECK contribution here
        done_d  = 1'b1;
        pass_d  = (fail_cnt_q == 3'd0);
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= '0;
      fail_cnt_q <= '0;
      ffi_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      fail_cnt_q <= fail_cnt_d;
      ffi_q      <= ffi_d;
    end
  end

  assign bus.A_drv          = vec_q[1];
  assign bus.B_drv          = vec_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_vec       = fail_vec_q;
  assign bus.fail_cnt       = fail_cnt_q;
  assign bus.first_fail_idx = ffi_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gate_bist_ctrl : directed bench, SETTLE_CYCLES=1 and =3 instances |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_gate_bist_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   fault;
  logic sel;

  gate_bist_ctrl_if bus1 ();
  gate_bist_ctrl_if bus3 ();

  gate_bist_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  gate_bist_ctrl #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gate unit model; fault 1 = AND stuck at 0, fault 2 = XOR inverted
  assign bus1.AND_in   = (fault == 1) ? 1'b0 : (bus1.A_drv & bus1.B_drv);
  assign bus1.OR_in    = bus1.A_drv | bus1.B_drv;
  assign bus1.NOT_A_in = ~bus1.A_drv;
  assign bus1.NAND_in  = ~(bus1.A_drv & bus1.B_drv);
  assign bus1.NOR_in   = ~(bus1.A_drv | bus1.B_drv);
  assign bus1.XOR_in   = (fault == 2) ? ~(bus1.A_drv ^ bus1.B_drv) : (bus1.A_drv ^ bus1.B_drv);
  assign bus1.XNOR_in  = ~(bus1.A_drv ^ bus1.B_drv);
  assign bus3.AND_in   = (fault == 1) ? 1'b0 : (bus3.A_drv & bus3.B_drv);
  assign bus3.OR_in    = bus3.A_drv | bus3.B_drv;
  assign bus3.NOT_A_in = ~bus3.A_drv;
  assign bus3.NAND_in  = ~(bus3.A_drv & bus3.B_drv);
  assign bus3.NOR_in   = ~(bus3.A_drv | bus3.B_drv);
  assign bus3.XOR_in   = (fault == 2) ? ~(bus3.A_drv ^ bus3.B_drv) : (bus3.A_drv ^ bus3.B_drv);
  assign bus3.XNOR_in  = ~(bus3.A_drv ^ bus3.B_drv);

  logic [1:0] ab_s;
  logic       busy_s, done_s, pass_s;
  logic [6:0] fv_s;
  logic [2:0] fc_s;
  logic [1:0] ffi_s;
  assign ab_s   = sel ? {bus3.A_drv, bus3.B_drv} : {bus1.A_drv, bus1.B_drv};
  assign busy_s = sel ? bus3.busy : bus1.busy;
  assign done_s = sel ? bus3.done : bus1.done;
  assign pass_s = sel ? bus3.pass : bus1.pass;
  assign fv_s   = sel ? bus3.fail_vec : bus1.fail_vec;
  assign fc_s   = sel ? bus3.fail_cnt : bus1.fail_cnt;
  assign ffi_s  = sel ? bus3.first_fail_idx : bus1.first_fail_idx;

  int         done_edge;
  logic [1:0] seq_r  [0:39];
  logic       busy_r [0:39];
  logic       pass_at0;
  logic [6:0] fv_at0;
  logic [2:0] fc_at0;

  task automatic set_start(input logic v);
    if (sel) bus3.start = v;
    else     bus1.start = v;
  endtask

  // Start a run (b2b: start is raised right now instead of after one more edge)
  // and follow it edge by edge until done or the budget runs out.
  task automatic run(input bit b2b, input int rp1, input int rp2, input int rp3);
    done_edge = -1;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    seq_r[0] = ab_s; busy_r[0] = busy_s;
    pass_at0 = pass_s; fv_at0 = fv_s; fc_at0 = fc_s;
    for (int k = 1; k < 40 && done_edge < 0; k++) begin
      if (k == rp1 || k == rp2 || k == rp3) set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      seq_r[k] = ab_s; busy_r[k] = busy_s;
      if (done_s) done_edge = k;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sel = 1'b0; fault = 0;
    bus1.start = 1'b0; bus3.start = 1'b0;
    #3;
    total++; if (bus1.A_drv !== 1'b0) begin bad++; $display("FAIL reset_A got=%b exp=0", bus1.A_drv); end
    total++; if (bus1.B_drv !== 1'b0) begin bad++; $display("FAIL reset_B got=%b exp=0", bus1.B_drv); end
    total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus1.busy); end
    total++; if (bus1.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus1.done); end
    total++; if (bus1.pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", bus1.pass); end
    total++; if (bus1.fail_vec !== 7'd0) begin bad++; $display("FAIL reset_fail_vec got=%b exp=0", bus1.fail_vec); end
    total++; if (bus1.fail_cnt !== 3'd0) begin bad++; $display("FAIL reset_fail_cnt got=%0d exp=0", bus1.fail_cnt); end
    total++; if (bus1.first_fail_idx !== 2'd0) begin bad++; $display("FAIL reset_ffi got=%0d exp=0", bus1.first_fail_idx); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if ({bus1.busy, bus1.done, bus3.busy, bus3.done} !== 4'b0000) begin
      bad++; $display("FAIL idle_no_start got=%b exp=0000", {bus1.busy, bus1.done, bus3.busy, bus3.done});
    end
  endtask

  task automatic test_golden;
    logic seq_ok;
    logic busy_ok;
    sel = 1'b0; fault = 0;
    run(1'b0, -1, -1, -1);
    total++; if (done_edge != 9) begin bad++; $display("FAIL golden_latency got=%0d exp=9", done_edge); end
    total++; if (pass_s !== 1'b1) begin bad++; $display("FAIL golden_pass got=%b exp=1", pass_s); end
    total++; if (fv_s !== 7'd0) begin bad++; $display("FAIL golden_fail_vec got=%b exp=0000000", fv_s); end
    total++; if (fc_s !== 3'd0) begin bad++; $display("FAIL golden_fail_cnt got=%0d exp=0", fc_s); end
    total++; if (ffi_s !== 2'd0) begin bad++; $display("FAIL golden_ffi got=%0d exp=0", ffi_s); end
    seq_ok = 1'b1;
    for (int k = 0; k < 8; k++) if (seq_r[k] !== 2'(k / 2)) seq_ok = 1'b0;
    total++; if (seq_ok !== 1'b1) begin
      bad++; $display("FAIL golden_ab_seq got=%b%b%b%b%b%b%b%b exp=0000010110101111",
                      seq_r[0], seq_r[1], seq_r[2], seq_r[3], seq_r[4], seq_r[5], seq_r[6], seq_r[7]);
    end
    busy_ok = 1'b1;
    for (int k = 0; k < 9; k++) if (busy_r[k] !== 1'b1) busy_ok = 1'b0;
    total++; if ({busy_ok, busy_s} !== 2'b10) begin bad++; $display("FAIL golden_busy got=%b exp=10", {busy_ok, busy_s}); end
    @(posedge clk); #1;
    total++; if ({done_s, pass_s, ab_s} !== 4'b0111) begin
      bad++; $display("FAIL golden_hold got=%b exp=0111", {done_s, pass_s, ab_s});
    end
  endtask

  task automatic test_and_stuck;
    sel = 1'b0; fault = 1;
    run(1'b0, -1, -1, -1);
    total++; if (done_edge != 9) begin bad++; $display("FAIL and_latency got=%0d exp=9", done_edge); end
    total++; if ({pass_s, fv_s, fc_s, ffi_s} !== {1'b0, 7'b0000001, 3'd1, 2'd3}) begin
      bad++; $display("FAIL and_stuck got=%b/%b/%0d/%0d exp=0/0000001/1/3", pass_s, fv_s, fc_s, ffi_s);
    end
  endtask

  task automatic test_xor_inv_then_b2b;
    sel = 1'b0; fault = 2;
    run(1'b0, -1, -1, -1);
    total++; if ({pass_s, fv_s, fc_s, ffi_s} !== {1'b0, 7'b0100000, 3'd4, 2'd0}) begin
      bad++; $display("FAIL xor_inv got=%b/%b/%0d/%0d exp=0/0100000/4/0", pass_s, fv_s, fc_s, ffi_s);
    end
    fault = 0;
    run(1'b1, -1, -1, -1);
    total++; if ({pass_at0, fv_at0, fc_at0} !== {1'b0, 7'd0, 3'd0}) begin
      bad++; $display("FAIL b2b_clear got=%b/%b/%0d exp=0/0000000/0", pass_at0, fv_at0, fc_at0);
    end
    total++; if (done_edge != 9) begin bad++; $display("FAIL b2b_latency got=%0d exp=9", done_edge); end
    total++; if ({pass_s, fv_s, fc_s, ffi_s} !== {1'b1, 7'd0, 3'd0, 2'd0}) begin
      bad++; $display("FAIL b2b_golden got=%b/%b/%0d/%0d exp=1/0000000/0/0", pass_s, fv_s, fc_s, ffi_s);
    end
  endtask

  task automatic test_restart_ignored;
    logic busy_ok;
    sel = 1'b0; fault = 0;
    run(1'b0, 3, 5, 9);
    total++; if (done_edge != 9) begin bad++; $display("FAIL restart_latency got=%0d exp=9", done_edge); end
    busy_ok = 1'b1;
    for (int k = 0; k < 9; k++) if (busy_r[k] !== 1'b1) busy_ok = 1'b0;
    total++; if ({busy_ok, busy_s, pass_s} !== 3'b101) begin
      bad++; $display("FAIL restart_busy_pass got=%b exp=101", {busy_ok, busy_s, pass_s});
    end
    @(posedge clk); #1;
    total++; if ({busy_s, done_s} !== 2'b00) begin
      bad++; $display("FAIL start_in_finish got=%b exp=00", {busy_s, done_s});
    end
  endtask

  task automatic test_async_reset;
    logic saw_done;
    sel = 1'b0; fault = 0;
    @(posedge clk); #1;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if ({ab_s, busy_s} !== 3'b101) begin bad++; $display("FAIL pre_reset_state got=%b exp=101", {ab_s, busy_s}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ab_s, busy_s, done_s, pass_s, fv_s, fc_s, ffi_s} !== 16'd0) begin
      bad++; $display("FAIL async_reset got=%b exp=0", {ab_s, busy_s, done_s, pass_s, fv_s, fc_s, ffi_s});
    end
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done_s !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done_s !== 1'b0 || busy_s !== 1'b0) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL aborted_run_activity got=%b exp=0", saw_done); end
    run(1'b0, -1, -1, -1);
    total++; if (done_edge != 9 || {pass_s, fv_s, fc_s} !== {1'b1, 7'd0, 3'd0}) begin
      bad++; $display("FAIL post_reset_run got=%0d/%b/%b/%0d exp=9/1/0000000/0", done_edge, pass_s, fv_s, fc_s);
    end
  endtask

  task automatic test_settle3;
    logic seq_ok;
    sel = 1'b1; fault = 0;
    run(1'b0, -1, -1, -1);
    total++; if (done_edge != 17) begin bad++; $display("FAIL settle3_latency got=%0d exp=17", done_edge); end
    seq_ok = 1'b1;
    for (int k = 0; k < 16; k++) if (seq_r[k] !== 2'(k / 4)) seq_ok = 1'b0;
    total++; if (seq_ok !== 1'b1) begin bad++; $display("FAIL settle3_ab_seq got=%b exp=1", seq_ok); end
    total++; if ({pass_s, fv_s, fc_s, ffi_s} !== {1'b1, 7'd0, 3'd0, 2'd0}) begin
      bad++; $display("FAIL settle3_results got=%b/%b/%0d/%0d exp=1/0000000/0/0", pass_s, fv_s, fc_s, ffi_s);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_golden();
    test_and_stuck();
    test_xor_inv_then_b2b();
    test_restart_ignored();
    test_async_reset();
    test_settle3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
